// File: rtl/shot_controller.sv
// Aim/fire controller for a trajectory game: player edits the shot with buttons,
// fires, waits for the trajectory calculator's verdict (or a timeout) and keeps score.
module shot_controller #(
    parameter int MAX_SHOTS = 8,
    parameter int TIMEOUT   = 63
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sel,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_fire,
    input  logic       result_valid,
    input  logic       hit,
    input  logic [4:0] positionx,
    output logic [4:0] x_pos,
    output logic [4:0] rise,
    output logic [4:0] run,
    output logic       direction,
    output logic       shoot,
    output logic       busy,
    output logic       game_over,
    output logic       last_hit,
    output logic       timeout_err,
    output logic [3:0] score,
    output logic [3:0] shots_left,
    output logic [4:0] last_x,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FIRE = 2'd1, S_WAIT = 2'd2, S_OVER = 2'd3} state_t;

    localparam logic [3:0] SHOTS = 4'(MAX_SHOTS);
    localparam logic [7:0] TMO   = 8'(TIMEOUT);

    state_t     r_state;
    logic [4:0] r_x_pos, r_rise, r_run, r_last_x;
    logic [3:0] r_score, r_shots_left;
    logic [7:0] r_cnt;
    logic       r_direction, r_shoot, r_busy, r_game_over, r_last_hit, r_timeout_err;
    logic       r_inc_prev, r_dec_prev, r_fire_prev, r_armed;

    logic       w_inc_edge, w_dec_edge, w_fire_edge, w_edit, w_last_shot;
    logic [7:0] w_cnt_next;

    // r_armed masks the first cycle after reset so a button held through release is not an edge.
    assign w_inc_edge  = r_armed & btn_inc  & ~r_inc_prev;
    assign w_dec_edge  = r_armed & btn_dec  & ~r_dec_prev;
    assign w_fire_edge = r_armed & btn_fire & ~r_fire_prev;
    assign w_edit      = w_inc_edge ^ w_dec_edge;
    assign w_last_shot = (r_shots_left == 4'd1);
    assign w_cnt_next  = r_cnt + 8'd1;

    function automatic logic [4:0] step_sat(input logic [4:0] v, input logic up, input logic [4:0] lo);
        if (up) return (v == 5'd31) ? v : v + 5'd1;
        else    return (v == lo)    ? v : v - 5'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_x_pos       <= 5'd16;
            r_rise        <= 5'd1;
            r_run         <= 5'd1;
            r_direction   <= 1'b1;
            r_shoot       <= 1'b0;
            r_busy        <= 1'b0;
            r_game_over   <= 1'b0;
            r_score       <= 4'd0;
            r_shots_left  <= SHOTS;
            r_last_x      <= 5'd0;
            r_last_hit    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_cnt         <= 8'd0;
            r_inc_prev    <= 1'b0;
            r_dec_prev    <= 1'b0;
            r_fire_prev   <= 1'b0;
            r_armed       <= 1'b0;
        end else begin
            r_armed     <= 1'b1;
            r_inc_prev  <= btn_inc;
            r_dec_prev  <= btn_dec;
            r_fire_prev <= btn_fire;
            case (r_state)
                S_IDLE: begin
                    if (w_fire_edge && r_shots_left != 4'd0) begin
                        r_state <= S_FIRE;
                        r_shoot <= 1'b1;
                        r_busy  <= 1'b1;
                    end else if (w_edit) begin
                        case (sel)
                            2'd0:    r_x_pos     <= step_sat(r_x_pos, w_inc_edge, 5'd0);
                            2'd1:    r_rise      <= step_sat(r_rise,  w_inc_edge, 5'd1);
                            2'd2:    r_run       <= step_sat(r_run,   w_inc_edge, 5'd1);
                            default: r_direction <= w_inc_edge;
                        endcase
                    end
                end
                S_FIRE: begin
                    r_state <= S_WAIT;
                    r_shoot <= 1'b0;
                    r_cnt   <= 8'd0;
                end
                S_WAIT: begin
                    r_cnt <= w_cnt_next;
                    // A result arriving on the timeout cycle still wins over the timeout.
                    if (result_valid || w_cnt_next == TMO) begin
                        r_last_hit    <= result_valid & hit;
                        r_timeout_err <= ~result_valid;
                        if (result_valid) r_last_x <= positionx;
                        if (result_valid && hit && r_score != 4'd15) r_score <= r_score + 4'd1;
                        r_shots_left  <= r_shots_left - 4'd1;
                        r_busy        <= 1'b0;
                        r_state       <= w_last_shot ? S_OVER : S_IDLE;
                        r_game_over   <= w_last_shot;
                    end
                end
                S_OVER: begin
                    if (w_fire_edge) begin
                        r_state       <= S_IDLE;
                        r_game_over   <= 1'b0;
                        r_shots_left  <= SHOTS;
                        r_score       <= 4'd0;
                        r_last_hit    <= 1'b0;
                        r_timeout_err <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign x_pos       = r_x_pos;
    assign rise        = r_rise;
    assign run         = r_run;
    assign direction   = r_direction;
    assign shoot       = r_shoot;
    assign busy        = r_busy;
    assign game_over   = r_game_over;
    assign last_hit    = r_last_hit;
    assign timeout_err = r_timeout_err;
    assign score       = r_score;
    assign shots_left  = r_shots_left;
    assign last_x      = r_last_x;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_shot_controller.sv
// Directed bench for shot_controller: a driver issues shots and pushes the expected
// outcome; a monitor pops and compares whenever a shot completes (busy falls).
module tb_shot_controller;

    localparam int MS = 8;
    localparam int TO = 4;
    localparam int W  = 18;

    logic       clk, rst_n;
    logic [1:0] sel;
    logic       btn_inc, btn_dec, btn_fire, result_valid, hit;
    logic [4:0] positionx;
    logic [4:0] x_pos, rise, run, last_x;
    logic       direction, shoot, busy, game_over, last_hit, timeout_err;
    logic [3:0] score, shots_left;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    shot_controller #(.MAX_SHOTS(MS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel),
        .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_fire(btn_fire),
        .result_valid(result_valid), .hit(hit), .positionx(positionx),
        .x_pos(x_pos), .rise(rise), .run(run), .direction(direction),
        .shoot(shoot), .busy(busy), .game_over(game_over), .last_hit(last_hit),
        .timeout_err(timeout_err), .score(score), .shots_left(shots_left),
        .last_x(last_x), .dbg_state(dbg_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // {shoot cycles, score, shots_left, last_x, last_hit, timeout_err, game_over}
    function automatic logic [W-1:0] pack(input int sc, input int s, input int sl,
                                          input int lx, input int lh, input int te, input int go);
        return {2'(sc), 4'(s), 4'(sl), 5'(lx), 1'(lh), 1'(te), 1'(go)};
    endfunction

    // monitor
    initial begin
        logic prev_busy;
        int   shoot_cnt;
        logic [W-1:0] e;
        prev_busy = 1'b0;
        shoot_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy = 1'b0;
                shoot_cnt = 0;
            end else begin
                if (shoot) shoot_cnt++;
                if (prev_busy && !busy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_shot_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("shot_result", int'(pack(shoot_cnt, score, shots_left, last_x,
                                                     last_hit, timeout_err, game_over)), int'(e));
                    end
                    shoot_cnt = 0;
                end
                prev_busy = busy;
            end
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // which: 0=inc 1=dec 2=inc+dec 3=fire
    task automatic press(input int which, input logic [1:0] s);
        sel = s;
        btn_inc  = (which == 0 || which == 2);
        btn_dec  = (which == 1 || which == 2);
        btn_fire = (which == 3);
        tick(1);
        btn_inc = 1'b0; btn_dec = 1'b0; btn_fire = 1'b0;
        tick(1);
    endtask

    // res_delay < 0: no result; otherwise result_valid is raised res_delay cycles after FIRE
    task automatic fire_shot(input int res_delay, input logic h, input logic [4:0] px,
                             input logic with_inc, input logic [W-1:0] e);
        int n;
        exp_q.push_back(e);
        btn_fire = 1'b1;
        btn_inc  = with_inc;
        tick(1);
        btn_fire = 1'b0;
        btn_inc  = 1'b0;
        chk("fire_shoot", shoot, 1);
        chk("fire_busy", busy, 1);
        if (res_delay >= 0) begin
            tick(res_delay);
            result_valid = 1'b1; hit = h; positionx = px;
            tick(1);
            result_valid = 1'b0; hit = 1'b0; positionx = 5'd0;
        end
        n = 0;
        while (busy && n < 20) begin
            tick(1);
            n++;
        end
        chk("shot_done_in_time", busy, 0);
        tick(1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_x_pos"}, x_pos, 16);
        chk({tag, "_rise"}, rise, 1);
        chk({tag, "_run"}, run, 1);
        chk({tag, "_direction"}, direction, 1);
        chk({tag, "_shoot"}, shoot, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_game_over"}, game_over, 0);
        chk({tag, "_score"}, score, 0);
        chk({tag, "_shots_left"}, shots_left, MS);
        chk({tag, "_last_x"}, last_x, 0);
        chk({tag, "_last_hit"}, last_hit, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
        chk({tag, "_state"}, dbg_state, 0);
    endtask

    // stimulus
    initial begin
        rst_n = 1'b0; sel = 2'd0;
        btn_inc = 1'b0; btn_dec = 1'b0; btn_fire = 1'b1;
        result_valid = 1'b0; hit = 1'b0; positionx = 5'd0;
        tick(3);
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick(3);
        chk("held_fire_no_edge_state", dbg_state, 0);
        chk("held_fire_no_edge_busy", busy, 0);
        btn_fire = 1'b0;
        tick(1);

        // aim editing and saturation
        repeat (3) press(0, 2'd1);
        chk("rise_3_inc", rise, 4);
        repeat (20) press(0, 2'd0);
        chk("x_pos_sat_31", x_pos, 31);
        press(1, 2'd2);
        chk("run_sat_1", run, 1);
        press(1, 2'd3);
        chk("dir_dec", direction, 0);
        press(0, 2'd3);
        chk("dir_inc", direction, 1);
        press(1, 2'd0);
        chk("x_pos_dec", x_pos, 30);
        press(2, 2'd0);
        chk("inc_dec_same_cycle", x_pos, 30);

        // hit, timeout, result on timeout cycle, late result ignored
        fire_shot(3, 1'b1, 5'd9, 1'b0, pack(1, 1, 7, 9, 1, 0, 0));
        chk("hit_state_idle", dbg_state, 0);
        fire_shot(-1, 1'b0, 5'd0, 1'b0, pack(1, 1, 6, 9, 0, 1, 0));
        fire_shot(4, 1'b0, 5'd3, 1'b0, pack(1, 1, 5, 3, 0, 0, 0));
        fire_shot(6, 1'b1, 5'd7, 1'b0, pack(1, 1, 4, 3, 0, 1, 0));
        chk("late_result_ignored_score", score, 1);
        chk("late_result_ignored_last_x", last_x, 3);

        // fire wins over inc in the same cycle
        sel = 2'd0;
        fire_shot(3, 1'b1, 5'd20, 1'b1, pack(1, 2, 3, 20, 1, 0, 0));
        chk("fire_discards_inc", x_pos, 30);

        // reset during WAIT
        btn_fire = 1'b1;
        tick(1);
        btn_fire = 1'b0;
        tick(2);
        chk("in_wait_before_reset", dbg_state, 2);
        rst_n = 1'b0;
        #1;
        check_reset_vals("reset_mid_wait");
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // play a full game of hits, then game over and reload
        for (int i = 0; i < MS; i++)
            fire_shot(3, 1'b1, 5'(i), 1'b0, pack(1, i + 1, MS - i - 1, i, 1, 0, (i == MS - 1) ? 1 : 0));
        chk("over_state", dbg_state, 3);
        chk("over_game_over", game_over, 1);
        press(0, 2'd0);
        chk("over_aim_ignored", x_pos, 16);
        press(3, 2'd0);
        chk("reload_state", dbg_state, 0);
        chk("reload_busy", busy, 0);
        chk("reload_shots_left", shots_left, MS);
        chk("reload_score", score, 0);
        chk("reload_last_hit", last_hit, 0);
        chk("reload_game_over", game_over, 0);
        chk("reload_last_x_kept", last_x, MS - 1);

        tick(2);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shot_controller.md
SHOT_CONTROLLER -- requirements
Module: shot_controller

Interface
REQ-001 SHALL have parameter MAX_SHOTS, default 8, shots per game (1..15).
REQ-002 SHALL have parameter TIMEOUT, default 63, max cycles waiting for a result (1..255).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port sel  input  2  aim field select: 0=x_pos, 1=rise, 2=run, 3=direction.
REQ-006 SHALL have ports btn_inc, btn_dec, btn_fire  input  1 each  synchronous player buttons, level.
REQ-007 SHALL have ports result_valid, hit  input  1 each  from trajectory calculator.
REQ-008 SHALL have port positionx  input  5  final x from trajectory calculator.
REQ-009 SHALL have ports x_pos, rise, run  output  5 each  shot parameters to calculator.
REQ-010 SHALL have port direction  output  1  0=left, 1=right.
REQ-011 SHALL have port shoot  output  1  one-cycle fire pulse to calculator.
REQ-012 SHALL have ports busy, game_over, last_hit, timeout_err  output  1 each  status.
REQ-013 SHALL have ports score, shots_left  output  4 each; last_x  output  5.

Function
REQ-014 SHALL rising-edge-detect btn_inc, btn_dec, btn_fire (registered previous value; one action per press).
REQ-015 SHALL implement states IDLE, FIRE, WAIT, OVER.
REQ-016 In IDLE, inc edge SHALL add 1 to selected field, dec edge subtract 1; x_pos saturates 0..31, rise/run saturate 1..31; direction: inc sets 1, dec sets 0.
REQ-017 Simultaneous inc and dec edges SHALL leave all aim fields unchanged.
REQ-018 Aim edits outside IDLE SHALL be ignored; x_pos/rise/run/direction SHALL hold stable from FIRE until return to IDLE.
REQ-019 IDLE: fire edge with shots_left>0 SHALL go to FIRE next cycle; fire edge takes precedence over inc/dec in the same cycle (edit discarded).
REQ-020 FIRE SHALL last exactly one cycle with shoot=1, then go to WAIT with timeout counter cleared; shoot SHALL be 0 in every other state.
REQ-021 WAIT: counter increments each cycle; result_valid=1 SHALL record last_hit=hit, last_x=positionx, timeout_err=0, score+=hit (saturate at 15), shots_left-=1.
REQ-022 WAIT: counter reaching TIMEOUT without result_valid SHALL record last_hit=0, timeout_err=1, last_x unchanged, shots_left-=1.
REQ-023 result_valid in the same cycle the counter reaches TIMEOUT SHALL be treated as a result (REQ-021), not a timeout.
REQ-024 After WAIT completion, next state SHALL be OVER if shots_left becomes 0, else IDLE.
REQ-025 result_valid outside WAIT SHALL be ignored.
REQ-026 OVER: game_over=1; fire edge SHALL reload shots_left=MAX_SHOTS, score=0, last_hit=0, timeout_err=0, go to IDLE; aim fields retained.
REQ-027 busy SHALL be 1 in FIRE and WAIT, 0 otherwise; game_over 1 only in OVER.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, x_pos=16, rise=1, run=1, direction=1, shoot=0, busy=0, game_over=0, score=0, shots_left=MAX_SHOTS, last_x=0, last_hit=0, timeout_err=0, edge registers=0, counter=0.
REQ-029 Reset asserted mid-FIRE or mid-WAIT SHALL abort the shot with no score/shots_left change surviving; a button held through reset release SHALL NOT register an edge.

Verification
REQ-030 Aim: sel=1, 3 inc presses from reset -> rise=4; sel=0, 20 inc presses -> x_pos=31 (saturated); sel=2, dec press -> run stays 1.
REQ-031 Hit shot: fire press -> shoot high exactly 1 cycle, busy=1; result_valid=1,hit=1,positionx=9 three cycles later -> score=1, shots_left=7, last_x=9, last_hit=1, IDLE.
REQ-032 Timeout: TIMEOUT=4, fire, no result_valid -> after 4 WAIT cycles timeout_err=1, shots_left=7, score=0.
REQ-033 Game over: MAX_SHOTS=2, two misses -> game_over=1, further fire ignored until one fire press reloads shots_left=2, score=0.
REQ-034 Collisions: inc+dec same cycle -> no change; result_valid on timeout cycle -> counted as result; rst_n low during WAIT -> all outputs at REQ-028 values asynchronously.
